pipelined_control_unit: RTL and testbench

PIPELINED_CONTROL_UNIT -- requirements
Module: pipelined_control_unit

---
 rtl/pipelined_control_unit.sv | 258 +++++++++++++++++++++++++
 tb/tb_pipelined_control_unit.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_control_unit.sv
// Pipelined control unit: combinational decode in ID, control carried ID/EX -> MEM_STAGES MEM regs -> WB.
// Optional load-use hazard detection is built when CU_LOADUSE_EN is defined.
module pipelined_control_unit #(
  parameter int MEM_STAGES = 1,
  parameter int ALUOP_W    = 4
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic [31:0]        imemload,
  input  logic               en,
  input  logic               flush,
  output logic               hazard,
  output logic [1:0]         ex_ALUsrc,
  output logic [ALUOP_W-1:0] ex_ALUop,
  output logic               ex_signzero,
  output logic [1:0]         ex_regdst,
  output logic               ex_branch,
  output logic [1:0]         ex_pcselect,
  output logic               mem_dmemREN,
  output logic               mem_dmemWEN,
  output logic               wb_regwrite,
  output logic [1:0]         wb_memtoreg,
  output logic               halt_out
);

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE   = 6'h05, OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D, OP_XORI  = 6'h0E, OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23, OP_SW    = 6'h2B, OP_HALT  = 6'h3F;

  localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_JR   = 6'h08;
  localparam logic [5:0] F_ADDU = 6'h21, F_SUBU = 6'h23, F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25, F_XOR  = 6'h26, F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A, F_SLTU = 6'h2B, F_HALT = 6'h3F;

  localparam logic [3:0] ALU_SLL  = 4'b0000, ALU_SRL  = 4'b0001, ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011, ALU_XOR  = 4'b0100, ALU_NOR = 4'b0101;
  localparam logic [3:0] ALU_ADDU = 4'b0110, ALU_SUBU = 4'b0111, ALU_SLT = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [1:0] SRC_IMM = 2'd1, SRC_SHAMT = 2'd2;
  localparam logic [1:0] DST_RD  = 2'd1, DST_R31   = 2'd2;
  localparam logic [1:0] PC_JR   = 2'd1, PC_BRANCH = 2'd2, PC_JUMP = 2'd3;
  localparam logic [1:0] WB_MEM  = 2'd1, WB_LUI    = 2'd2, WB_PC4  = 2'd3;

  typedef struct packed {
    logic [1:0]         alusrc;
    logic [ALUOP_W-1:0] aluop;
    logic               signzero;
    logic [1:0]         regdst;
    logic               branch;
    logic [1:0]         pcselect;
  } ex_ctrl_t;

  typedef struct packed {
    logic ren;
    logic wen;
  } mem_ctrl_t;

  typedef struct packed {
    logic       regwrite;
    logic [1:0] memtoreg;
    logic       halt;
  } wb_ctrl_t;

  typedef struct packed {
    ex_ctrl_t  ex;
    mem_ctrl_t mem;
    wb_ctrl_t  wb;
  } ctrl_t;

  logic [5:0] opcode, funct;
  logic [4:0] rs, rt;
  assign opcode = imemload[31:26];
  assign rs     = imemload[25:21];
  assign rt     = imemload[20:16];
  assign funct  = imemload[5:0];

  logic unused_imem;
  assign unused_imem = ^{imemload[25:16], imemload[15:6]};

  ctrl_t      dec;
  logic       r_ok, i_ok, i_sext;
  logic [3:0] r_alu, i_alu;

  // R-type ALU ops and immediate ALU ops share their trailing field setup below the case.
  always_comb begin
    dec    = '0;
    r_ok   = 1'b0;
    r_alu  = ALU_SLL;
    i_ok   = 1'b0;
    i_alu  = ALU_SLL;
    i_sext = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_SLL:  begin r_ok = 1'b1; r_alu = ALU_SLL;  dec.ex.alusrc = SRC_SHAMT; end
          F_SRL:  begin r_ok = 1'b1; r_alu = ALU_SRL;  dec.ex.alusrc = SRC_SHAMT; end
          F_JR:   dec.ex.pcselect = PC_JR;
          F_ADDU: begin r_ok = 1'b1; r_alu = ALU_ADDU; end
          F_SUBU: begin r_ok = 1'b1; r_alu = ALU_SUBU; end
          F_AND:  begin r_ok = 1'b1; r_alu = ALU_AND;  end
          F_OR:   begin r_ok = 1'b1; r_alu = ALU_OR;   end
          F_XOR:  begin r_ok = 1'b1; r_alu = ALU_XOR;  end
          F_NOR:  begin r_ok = 1'b1; r_alu = ALU_NOR;  end
          F_SLT:  begin r_ok = 1'b1; r_alu = ALU_SLT;  end
          F_SLTU: begin r_ok = 1'b1; r_alu = ALU_SLTU; end
          default: ;
        endcase
      end
      OP_ADDIU: begin i_ok = 1'b1; i_alu = ALU_ADDU; i_sext = 1'b1; end
      OP_SLTI:  begin i_ok = 1'b1; i_alu = ALU_SLT;  i_sext = 1'b1; end
      OP_SLTIU: begin i_ok = 1'b1; i_alu = ALU_SLTU; i_sext = 1'b1; end
      OP_ANDI:  begin i_ok = 1'b1; i_alu = ALU_AND;  end
      OP_ORI:   begin i_ok = 1'b1; i_alu = ALU_OR;   end
      OP_XORI:  begin i_ok = 1'b1; i_alu = ALU_XOR;  end
      OP_LW: begin
        dec.mem.ren      = 1'b1;
        dec.ex.alusrc    = SRC_IMM;
        dec.ex.signzero  = 1'b1;
        dec.ex.aluop     = ALUOP_W'(ALU_ADDU);
        dec.wb.memtoreg  = WB_MEM;
        dec.wb.regwrite  = 1'b1;
      end
      OP_SW: begin
        dec.mem.wen      = 1'b1;
        dec.ex.alusrc    = SRC_IMM;
        dec.ex.signzero  = 1'b1;
        dec.ex.aluop     = ALUOP_W'(ALU_ADDU);
      end
      OP_BEQ, OP_BNE: begin
        dec.ex.aluop     = ALUOP_W'(ALU_SUBU);
        dec.ex.signzero  = 1'b1;
        dec.ex.pcselect  = PC_BRANCH;
        dec.ex.branch    = (opcode == OP_BEQ);
      end
      OP_LUI: begin
        dec.wb.memtoreg  = WB_LUI;
        dec.wb.regwrite  = 1'b1;
      end
      OP_J:   dec.ex.pcselect = PC_JUMP;
      OP_JAL: begin
        dec.ex.pcselect  = PC_JUMP;
        dec.ex.regdst    = DST_R31;
        dec.wb.memtoreg  = WB_PC4;
        dec.wb.regwrite  = 1'b1;
      end
      OP_HALT: dec.wb.halt = (funct == F_HALT);
      default: ;
    endcase
    if (r_ok) begin
      dec.ex.aluop    = ALUOP_W'(r_alu);
      dec.ex.regdst   = DST_RD;
      dec.wb.regwrite = 1'b1;
    end
    if (i_ok) begin
      dec.ex.alusrc   = SRC_IMM;
      dec.ex.aluop    = ALUOP_W'(i_alu);
      dec.ex.signzero = i_sext;
      dec.wb.regwrite = 1'b1;
    end
  end

  // flush squashes ID/EX even while the pipeline is frozen; a stall bubble needs en.
  logic load_bubble;
  assign load_bubble = flush | (en & hazard);

  ctrl_t idex_q, idex_d;

  always_comb begin
    idex_d = idex_q;
    if (load_bubble) idex_d = '0;
    else if (en)     idex_d = dec;
  end

`ifdef CU_LOADUSE_EN
  logic       idex_load_q, idex_load_d;
  logic [4:0] idex_rt_q, idex_rt_d;

  assign hazard = idex_load_q && (idex_rt_q != 5'd0) &&
                  ((idex_rt_q == rs) || (idex_rt_q == rt));

  always_comb begin
    idex_load_d = idex_load_q;
    idex_rt_d   = idex_rt_q;
    if (load_bubble) begin
      idex_load_d = 1'b0;
      idex_rt_d   = 5'd0;
    end else if (en) begin
      idex_load_d = (opcode == OP_LW);
      idex_rt_d   = rt;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      idex_load_q <= 1'b0;
      idex_rt_q   <= 5'd0;
    end else begin
      idex_load_q <= idex_load_d;
      idex_rt_q   <= idex_rt_d;
    end
  end
`else
  assign hazard = 1'b0;
`endif

  // Only the first MEM stage drives memory strobes; later stages carry WB control only.
  mem_ctrl_t mem_rw_q, mem_rw_d;
  wb_ctrl_t  mem_wb_q [MEM_STAGES];
  wb_ctrl_t  mem_wb_d [MEM_STAGES];
  wb_ctrl_t  wb_q, wb_d;
  logic      halt_q, halt_d;

  always_comb begin
    mem_rw_d = mem_rw_q;
    mem_wb_d = mem_wb_q;
    wb_d     = wb_q;
    if (en) begin
      mem_rw_d    = idex_q.mem;
      mem_wb_d[0] = idex_q.wb;
      for (int i = 1; i < MEM_STAGES; i++) mem_wb_d[i] = mem_wb_q[i-1];
      wb_d        = mem_wb_q[MEM_STAGES-1];
    end
    halt_d = halt_q | wb_q.halt;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      idex_q   <= '0;
      mem_rw_q <= '0;
      for (int i = 0; i < MEM_STAGES; i++) mem_wb_q[i] <= '0;
      wb_q     <= '0;
      halt_q   <= 1'b0;
    end else begin
      idex_q   <= idex_d;
      mem_rw_q <= mem_rw_d;
      for (int i = 0; i < MEM_STAGES; i++) mem_wb_q[i] <= mem_wb_d[i];
      wb_q     <= wb_d;
      halt_q   <= halt_d;
    end
  end

  assign ex_ALUsrc   = idex_q.ex.alusrc;
  assign ex_ALUop    = idex_q.ex.aluop;
  assign ex_signzero = idex_q.ex.signzero;
  assign ex_regdst   = idex_q.ex.regdst;
  assign ex_branch   = idex_q.ex.branch;
  assign ex_pcselect = idex_q.ex.pcselect;
  assign mem_dmemREN = mem_rw_q.ren;
  assign mem_dmemWEN = mem_rw_q.wen;
  assign wb_regwrite = wb_q.regwrite;
  assign wb_memtoreg = wb_q.memtoreg;
  // Halt is visible in the same cycle it reaches WB, then held by halt_q.
  assign halt_out    = halt_q | wb_q.halt;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: two instances (MEM_STAGES=1 and 3) share stimulus and are compared
// every cycle against a mnemonic-level pipeline model, plus a decode vector table and directed sequences.
module tb_pipelined_control_unit;

`ifdef CU_LOADUSE_EN
  localparam bit LOADUSE = 1'b1;
`else
  localparam bit LOADUSE = 1'b0;
`endif

  logic        clk, rst_n, en, flush;
  logic [31:0] ins;

  logic       hz1, hz3, sz1, sz3, br1, br3, ren1, ren3, wen1, wen3, rw1, rw3, halt1, halt3;
  logic [1:0] src1, src3, dst1, dst3, pcs1, pcs3, m2r1, m2r3;
  logic [3:0] alu1, alu3;
  logic [18:0] act [2];

  pipelined_control_unit #(.MEM_STAGES(1), .ALUOP_W(4)) dut1 (
    .CLK(clk), .nRST(rst_n), .imemload(ins), .en(en), .flush(flush), .hazard(hz1),
    .ex_ALUsrc(src1), .ex_ALUop(alu1), .ex_signzero(sz1), .ex_regdst(dst1), .ex_branch(br1),
    .ex_pcselect(pcs1), .mem_dmemREN(ren1), .mem_dmemWEN(wen1), .wb_regwrite(rw1),
    .wb_memtoreg(m2r1), .halt_out(halt1));

  pipelined_control_unit #(.MEM_STAGES(3), .ALUOP_W(4)) dut3 (
    .CLK(clk), .nRST(rst_n), .imemload(ins), .en(en), .flush(flush), .hazard(hz3),
    .ex_ALUsrc(src3), .ex_ALUop(alu3), .ex_signzero(sz3), .ex_regdst(dst3), .ex_branch(br3),
    .ex_pcselect(pcs3), .mem_dmemREN(ren3), .mem_dmemWEN(wen3), .wb_regwrite(rw3),
    .wb_memtoreg(m2r3), .halt_out(halt3));

  assign act[0] = {hz1, src1, alu1, sz1, dst1, br1, pcs1, ren1, wen1, rw1, m2r1, halt1};
  assign act[1] = {hz3, src3, alu3, sz3, dst3, br3, pcs3, ren3, wen3, rw3, m2r3, halt3};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, a, e);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_NONE, M_SLL, M_SRL, M_JR, M_ADDU, M_SUBU, M_AND, M_OR, M_XOR, M_NOR, M_SLT,
                M_SLTU, M_ADDIU, M_SLTI, M_SLTIU, M_ANDI, M_ORI, M_XORI, M_LW, M_SW, M_BEQ,
                M_BNE, M_LUI, M_J, M_JAL, M_HALT} mn_t;

  typedef struct packed {
    logic [1:0] alusrc; logic [3:0] aluop; logic signzero; logic [1:0] regdst; logic branch;
    logic [1:0] pcsel; logic ren; logic wen; logic regwrite; logic [1:0] memtoreg; logic halt;
    logic is_load; logic [4:0] rt;
  } ctl_t;

  function automatic mn_t mnemonic(input logic [31:0] w);
    logic [5:0] fn;
    fn = w[5:0];
    case (w[31:26])
      6'h00: case (fn)
        6'h00: return M_SLL;  6'h02: return M_SRL;  6'h08: return M_JR;   6'h21: return M_ADDU;
        6'h23: return M_SUBU; 6'h24: return M_AND;  6'h25: return M_OR;   6'h26: return M_XOR;
        6'h27: return M_NOR;  6'h2A: return M_SLT;  6'h2B: return M_SLTU; default: return M_NONE;
      endcase
      6'h02: return M_J;     6'h03: return M_JAL;   6'h04: return M_BEQ;   6'h05: return M_BNE;
      6'h09: return M_ADDIU; 6'h0A: return M_SLTI;  6'h0B: return M_SLTIU; 6'h0C: return M_ANDI;
      6'h0D: return M_ORI;   6'h0E: return M_XORI;  6'h0F: return M_LUI;   6'h23: return M_LW;
      6'h2B: return M_SW;
      6'h3F: return (fn == 6'h3F) ? M_HALT : M_NONE;
      default: return M_NONE;
    endcase
  endfunction

  function automatic logic [3:0] alu_of(input mn_t m);
    case (m)
      M_SRL: return 4'd1;
      M_AND, M_ANDI: return 4'd2;
      M_OR, M_ORI: return 4'd3;
      M_XOR, M_XORI: return 4'd4;
      M_NOR: return 4'd5;
      M_ADDU, M_ADDIU, M_LW, M_SW: return 4'd6;
      M_SUBU, M_BEQ, M_BNE: return 4'd7;
      M_SLT, M_SLTI: return 4'd8;
      M_SLTU, M_SLTIU: return 4'd9;
      default: return 4'd0;
    endcase
  endfunction

  function automatic ctl_t ref_decode(input logic [31:0] w);
    ctl_t c;
    mn_t  m;
    c = '0;
    m = mnemonic(w);
    c.aluop = alu_of(m);
    case (m)
      M_SLL, M_SRL: begin c.alusrc = 2; c.regdst = 1; c.regwrite = 1; end
      M_ADDU, M_SUBU, M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_SLTU: begin c.regdst = 1; c.regwrite = 1; end
      M_JR: c.pcsel = 1;
      M_ADDIU, M_SLTI, M_SLTIU: begin c.alusrc = 1; c.signzero = 1; c.regwrite = 1; end
      M_ANDI, M_ORI, M_XORI: begin c.alusrc = 1; c.regwrite = 1; end
      M_LW: begin c.ren = 1; c.alusrc = 1; c.signzero = 1; c.memtoreg = 1; c.regwrite = 1; end
      M_SW: begin c.wen = 1; c.alusrc = 1; c.signzero = 1; end
      M_BEQ, M_BNE: begin c.signzero = 1; c.pcsel = 2; c.branch = (m == M_BEQ); end
      M_LUI: begin c.memtoreg = 2; c.regwrite = 1; end
      M_J: c.pcsel = 3;
      M_JAL: begin c.pcsel = 3; c.memtoreg = 3; c.regdst = 2; c.regwrite = 1; end
      M_HALT: c.halt = 1;
      default: ;
    endcase
    c.is_load = (m == M_LW);
    c.rt = w[20:16];
    return c;
  endfunction

  // pipe[k][0] is ID/EX, [1] the first MEM stage, [stages+1] WB.
  ctl_t pipe [2][6];
  logic sticky [2];

  function automatic int stages(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic model_hz(input int k);
    ctl_t e;
    e = pipe[k][0];
    return LOADUSE && e.is_load && (e.rt != 5'd0) && (e.rt == ins[25:21] || e.rt == ins[20:16]);
  endfunction

  function automatic logic [18:0] exp_vec(input int k);
    ctl_t e, m, w;
    e = pipe[k][0];
    m = pipe[k][1];
    w = pipe[k][stages(k) + 1];
    return {model_hz(k), e.alusrc, e.aluop, e.signzero, e.regdst, e.branch, e.pcsel,
            m.ren, m.wen, w.regwrite, w.memtoreg, sticky[k] | w.halt};
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 6; i++) pipe[k][i] = '0;
      sticky[k] = 1'b0;
    end
  endtask

  task automatic advance();
    logic h;
    for (int k = 0; k < 2; k++) begin
      h = model_hz(k);
      sticky[k] = sticky[k] | pipe[k][stages(k) + 1].halt;
      if (en) begin
        for (int i = 5; i > 0; i--) pipe[k][i] = pipe[k][i-1];
        pipe[k][0] = (flush || h) ? '0 : ref_decode(ins);
      end else if (flush) begin
        pipe[k][0] = '0;
      end
    end
  endtask

  // ---------------- drivers ----------------
  // Called just after a rising edge; leaves the bench at the following falling edge.
  task automatic apply(input logic [31:0] i, input logic e, input logic f);
    ins = i; en = e; flush = f;
    @(negedge clk);
    chk("model_s1", 32'(act[0]), 32'(exp_vec(0)));
    chk("model_s3", 32'(act[1]), 32'(exp_vec(1)));
  endtask

  task automatic tick();
    advance();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    #2;
    chk("rst_zero_s1", 32'(act[0]), 32'd0);
    chk("rst_zero_s3", 32'(act[1]), 32'd0);
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_ins();
    logic [5:0] op, fn;
    logic [31:0] w;
    int r;
    r = $urandom_range(0, 99);
    if (r < 2) return 32'hFFFF_FFFF;
    w = $urandom;
    w[25:21] = 5'($urandom_range(0, 3));
    w[20:16] = 5'($urandom_range(0, 3));
    if (r < 45) begin
      case ($urandom_range(0, 11))
        0: fn = 6'h00; 1: fn = 6'h02; 2: fn = 6'h08; 3: fn = 6'h21; 4: fn = 6'h23; 5: fn = 6'h24;
        6: fn = 6'h25; 7: fn = 6'h26; 8: fn = 6'h27; 9: fn = 6'h2A; 10: fn = 6'h2B; default: fn = 6'h3F;
      endcase
      w[31:26] = 6'h00;
      w[5:0] = fn;
    end else begin
      case ($urandom_range(0, 13))
        0: op = 6'h02; 1: op = 6'h03; 2: op = 6'h04; 3: op = 6'h05; 4: op = 6'h09; 5: op = 6'h0A;
        6: op = 6'h0B; 7: op = 6'h0C; 8: op = 6'h0D; 9: op = 6'h0E; 10: op = 6'h0F; 11: op = 6'h23;
        12: op = 6'h2B; default: op = 6'h1F;
      endcase
      w[31:26] = op;
    end
    return w;
  endfunction

  function automatic ctl_t mk(input logic [1:0] s, input logic [3:0] a, input logic z,
                              input logic [1:0] d, input logic b, input logic [1:0] p,
                              input logic rn, input logic wn, input logic rw, input logic [1:0] mt);
    ctl_t c;
    c = '0;
    c.alusrc = s; c.aluop = a; c.signzero = z; c.regdst = d; c.branch = b; c.pcsel = p;
    c.ren = rn; c.wen = wn; c.regwrite = rw; c.memtoreg = mt;
    return c;
  endfunction

  typedef struct { logic [31:0] ins; ctl_t exp; } vec_t;
  vec_t tbl [16];

  localparam logic [31:0] NOP = 32'h0000_0000;

  initial begin
    tbl[0]  = '{32'h0022_1821, mk(0, 6, 0, 1, 0, 0, 0, 0, 1, 0)}; // ADDU r3
    tbl[1]  = '{32'h0002_1080, mk(2, 0, 0, 1, 0, 0, 0, 0, 1, 0)}; // SLL
    tbl[2]  = '{32'h0002_1082, mk(2, 1, 0, 1, 0, 0, 0, 0, 1, 0)}; // SRL
    tbl[3]  = '{32'h0022_182B, mk(0, 9, 0, 1, 0, 0, 0, 0, 1, 0)}; // SLTU
    tbl[4]  = '{32'h03E0_0008, mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0)}; // JR
    tbl[5]  = '{32'h2422_0005, mk(1, 6, 1, 0, 0, 0, 0, 0, 1, 0)}; // ADDIU
    tbl[6]  = '{32'h2822_0005, mk(1, 8, 1, 0, 0, 0, 0, 0, 1, 0)}; // SLTI
    tbl[7]  = '{32'h3422_0005, mk(1, 3, 0, 0, 0, 0, 0, 0, 1, 0)}; // ORI
    tbl[8]  = '{32'h3822_0005, mk(1, 4, 0, 0, 0, 0, 0, 0, 1, 0)}; // XORI
    tbl[9]  = '{32'h8C22_0004, mk(1, 6, 1, 0, 0, 0, 1, 0, 1, 1)}; // LW
    tbl[10] = '{32'hAC22_0008, mk(1, 6, 1, 0, 0, 0, 0, 1, 0, 0)}; // SW
    tbl[11] = '{32'h1422_0003, mk(0, 7, 1, 0, 0, 2, 0, 0, 0, 0)}; // BNE
    tbl[12] = '{32'h3C02_1234, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2)}; // LUI
    tbl[13] = '{32'h0C00_0010, mk(0, 0, 0, 2, 0, 3, 0, 0, 1, 3)}; // JAL
    tbl[14] = '{32'h7C00_0000, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)}; // undefined opcode
    tbl[15] = '{32'h0000_003F, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)}; // undefined funct

    rst_n = 1'b0; ins = NOP; en = 1'b0; flush = 1'b0;
    model_clear();
    #2;
    chk("reset_s1", 32'(act[0]), 32'd0);
    chk("reset_s3", 32'(act[1]), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Decode table: EX fields one cycle after issue, MEM at two, WB (MEM_STAGES=1) at three.
    for (int v = 0; v < 16; v++) begin
      apply(tbl[v].ins, 1, 0); tick();
      apply(NOP, 1, 0);
      chk($sformatf("tbl%0d_ex", v), 32'({src1, alu1, sz1, dst1, br1, pcs1}),
          32'({tbl[v].exp.alusrc, tbl[v].exp.aluop, tbl[v].exp.signzero, tbl[v].exp.regdst,
               tbl[v].exp.branch, tbl[v].exp.pcsel}));
      tick();
      apply(NOP, 1, 0);
      chk($sformatf("tbl%0d_mem", v), 32'({ren1, wen1, ren3, wen3}),
          32'({tbl[v].exp.ren, tbl[v].exp.wen, tbl[v].exp.ren, tbl[v].exp.wen}));
      tick();
      apply(NOP, 1, 0);
      chk($sformatf("tbl%0d_wb", v), 32'({rw1, m2r1}), 32'({tbl[v].exp.regwrite, tbl[v].exp.memtoreg}));
      tick();
    end

    // Load-use: LW r2 followed by ADDU reading r2.
    apply(32'h8C22_0004, 1, 0); tick();
    apply(32'h0042_1821, 1, 0);
    chk("lu_hazard_s1", 32'(hz1), 32'(LOADUSE));
    chk("lu_hazard_s3", 32'(hz3), 32'(LOADUSE));
    tick();
    apply(32'h0042_1821, 1, 0);
    chk("lu_ex_after", 32'({src1, alu1, sz1, dst1, br1, pcs1}),
        LOADUSE ? 32'd0 : 32'({2'd0, 4'd6, 1'b0, 2'd1, 1'b0, 2'd0}));
    chk("lu_mem_ren", 32'({ren1, ren3}), 32'b11);
    tick();
    apply(NOP, 1, 0); tick();

    // Taken branch: BEQ reaches EX, the following J is flushed.
    apply(32'h1022_0003, 1, 0); tick();
    apply(32'h0800_0010, 1, 1);
    chk("br_ex", 32'({pcs1, br1}), 32'({2'd2, 1'b1}));
    tick();
    apply(NOP, 1, 0);
    chk("flush_ex", 32'({src1, alu1, sz1, dst1, br1, pcs1}), 32'd0);
    tick();

    // SW frozen in MEM while en=0, then an asynchronous reset mid-chain.
    rst_pulse();
    apply(32'hAC22_0008, 1, 0); tick();
    apply(NOP, 1, 0); tick();
    for (int c = 0; c < 4; c++) begin
      apply(NOP, 0, 0);
      chk($sformatf("sw_frozen_c%0d", c), 32'({wen1, wen3}), 32'b11);
      tick();
    end
    rst_pulse();
    for (int c = 0; c < 8; c++) begin
      apply(NOP, 1, 0);
      chk($sformatf("sw_gone_c%0d", c), 32'({wen1, wen3}), 32'd0);
      tick();
    end

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) rst_pulse();
      apply(rand_ins(), ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0));
      tick();
    end

    // Halt with MEM_STAGES=3 appears exactly five cycles after issue and is sticky.
    rst_pulse();
    apply(32'hFFFF_FFFF, 1, 0); tick();
    for (int c = 1; c <= 6; c++) begin
      apply(NOP, 1, 0);
      chk($sformatf("halt_s3_c%0d", c), 32'(halt3), 32'(c >= 5));
      tick();
    end
    for (int c = 0; c < 3; c++) begin
      apply(NOP, 0, 1);
      chk($sformatf("halt_hold_c%0d", c), 32'({halt1, halt3}), 32'b11);
      tick();
    end
    rst_pulse();
    apply(NOP, 1, 0);
    chk("halt_cleared", 32'({halt1, halt3}), 32'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
